memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- EX/MEM pipeline register plus load/store unit; consumes the execute-stage result, store data and control, and drives the MEM/WB register inputs.
- Runs a valid/ready request and valid response handshake to data memory, with byte/half/word lane steering and load sign/zero extension.
- Returns ALUResultM, RdM and RegWriteM to the forwarding path.
- Asserts MemBusyM to stall upstream stages while an access is outstanding.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 supported (4 byte lanes)
ADDR_WIDTH, 32, data memory byte-address width
REG_FILE_ADDRESS_WIDTH, 5, destination register index width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
ALUResultE  in  DATA_WIDTH  address or ALU result from execute
WriteDataE  in  DATA_WIDTH  forwarded store data from execute
RdE  in  REG_FILE_ADDRESS_WIDTH  destination register
RegWriteE  in  1  register write enable
MemReadE  in  1  load
MemWriteE  in  1  store
Funct3E  in  3  access size/sign
ResultSrcE  in  2  writeback select, passed through
PCPlus4E  in  DATA_WIDTH  passed through
ALUResultM  out  DATA_WIDTH  registered ALU result (forwarding, MEM/WB)
RdM  out  REG_FILE_ADDRESS_WIDTH  registered destination
RegWriteM  out  1  registered write enable, masked on misalign
ResultSrcM  out  2  registered
PCPlus4M  out  DATA_WIDTH  registered
ReadDataM  out  DATA_WIDTH  extended load data
MemBusyM  out  1  stall request to hazard logic
MisalignM  out  1  current op misaligned, access suppressed
mem_req_valid  out  1  request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits zero)
mem_we  out  1  1 = store
mem_wstrb  out  4  byte enables
mem_wdata  out  DATA_WIDTH  lane-shifted store data
mem_rsp_valid  in  1  load response valid
mem_rdata  in  DATA_WIDTH  raw load word

Behaviour:
- Reset (async, active-high): all EX/MEM fields cleared to 0, state IDLE, ReadDataM 0; so every output is 0, including MemBusyM, MisalignM and mem_req_valid.
- EX/MEM register loads all *E inputs on each rising edge where MemBusyM=0; it holds while MemBusyM=1.
- op = (MemReadM | MemWriteM) & ~MisalignM.
- MisalignM = mem op with (half and addr[0]) or (word and addr[1:0]!=0).
  - When MisalignM=1: no request is issued, MemBusyM=0, RegWriteM forced 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: mem_req_valid = op.
    - Handshake with a store: go to DONE.
    - Handshake with a load: go to WAIT.
    - No handshake: stay in IDLE.
  - WAIT: mem_req_valid=0. On mem_rsp_valid, capture the extended mem_rdata into ReadDataM and go to DONE.
  - DONE: mem_req_valid=0, next state IDLE.
- MemBusyM = op & (state != DONE), combinational. The register advances on the DONE-state edge, so a back-to-back op is seen fresh in IDLE.
- Latency with ready=1 and response one cycle after acceptance:
  - Store: 1 stall cycle.
  - Load: 2 stall cycles.
  - Non-memory op: 0 stall cycles.
- mem_rsp_valid outside WAIT is ignored.
- Request fields stay stable while mem_req_valid=1 and ready=0, because the register is held.
- Stores:
  - SB (000): wstrb = 1 << addr[1:0]; wdata = byte replicated to all 4 lanes.
  - SH (001): wstrb = 0011 or 1100 by addr[1]; wdata = half replicated.
  - SW (010): wstrb = 1111.
- Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Select the lane by addr[1:0]; sign-extend or zero-extend per funct3.
- Undefined funct3 is treated as word access.
- ReadDataM holds its last value outside load completion.
- Reset mid-access: an in-flight response is dropped and the FSM returns to IDLE; the memory model must tolerate the lost response.

Decomposition:
- Shared package riscv_pkg:
  - funct3 load/store encodings
  - lsu_state_t enum {IDLE, WAIT, DONE}
  - ResultSrc encodings
- One combinational sub-module, load_store_align, holds store lane steering/wstrb and load extraction/extension. The FSM and pipeline register stay in memory_stage.

Test Plan:
- ALU op (RegWriteE=1, RdE=5, ALUResultE=0x1234), no mem op -> next cycle ALUResultM=0x1234, RdM=5, MemBusyM=0, mem_req_valid=0.
- SB, addr 0x103, data 0x000000AB, ready=1 -> mem_addr=0x100, wstrb=1000, wdata=0xABABABAB; MemBusyM high 1 cycle.
- LH, addr 0x102, rdata 0x8001xxxx, rsp 1 cycle after accept -> ReadDataM=0xFFFF8001, 2 stall cycles; LHU gives 0x00008001.
- LW with ready low 3 cycles -> mem_req_valid and mem_addr stable throughout, EX/MEM held, completes after handshake plus response.
- SW at addr 0x102 -> MisalignM=1, no request, RegWriteM=0, MemBusyM=0.
- Assert rst during WAIT, then deliver rsp_valid -> response ignored, all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the memory stage: funct3 access sizes, LSU state
// machine states and writeback select values.
package riscv_pkg;

   // Load and store funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Writeback result select
   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_MEM  = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Access size from funct3 low bits; anything not byte/half is a word
   function automatic logic is_byte(input logic [2:0] f3);
      return (f3[1:0] == 2'b00);
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return (f3[1:0] == 2'b01);
   endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Byte-lane steering for stores (strobes, replicated data) and lane
// extraction plus sign/zero extension for loads. Purely combinational.
module load_store_align
   import riscv_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_word,
   output logic [3:0]  o_wstrb,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_unsigned;

   // Store lanes: data is replicated so the strobe alone picks the lane
   always_comb begin
      o_wstrb = 4'b1111;
      o_wdata = i_store_data;
      if (is_byte(i_funct3)) begin
         o_wstrb = 4'b0001 << i_addr_lo;
         o_wdata = {4{i_store_data[7:0]}};
      end else if (is_half(i_funct3)) begin
         o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         o_wdata = {2{i_store_data[15:0]}};
      end
   end

   // Load lanes: pick the addressed byte/half and extend per funct3[2]
   always_comb begin
      w_unsigned = i_funct3[2];
      case (i_addr_lo)
         2'd0:    w_byte = i_load_word[7:0];
         2'd1:    w_byte = i_load_word[15:8];
         2'd2:    w_byte = i_load_word[23:16];
         default: w_byte = i_load_word[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];
      o_load_data = i_load_word;
      if (is_byte(i_funct3)) begin
         o_load_data = {{24{w_byte[7] & ~w_unsigned}}, w_byte};
      end else if (is_half(i_funct3)) begin
         o_load_data = {{16{w_half[15] & ~w_unsigned}}, w_half};
      end
   end

endmodule

// File: rtl/memory_stage.sv
// EX/MEM pipeline register plus load/store unit. One access at a time:
// the register holds while MemBusyM is high, which also keeps the request
// fields stable until the memory accepts them.
// Request handshake: a request transfers on a rising edge where
// mem_req_valid and mem_req_ready are both 1; once valid is raised the
// request fields stay stable until that edge. Responses are a single
// mem_rsp_valid pulse, honoured only in WAIT.
module memory_stage
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH             = 32,
   parameter int ADDR_WIDTH             = 32,
   parameter int REG_FILE_ADDRESS_WIDTH = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             ALUResultE,
   input  logic [DATA_WIDTH-1:0]             WriteDataE,
   input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
   input  logic                              RegWriteE,
   input  logic                              MemReadE,
   input  logic                              MemWriteE,
   input  logic [2:0]                        Funct3E,
   input  logic [1:0]                        ResultSrcE,
   input  logic [DATA_WIDTH-1:0]             PCPlus4E,
   output logic [DATA_WIDTH-1:0]             ALUResultM,
   output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
   output logic                              RegWriteM,
   output logic [1:0]                        ResultSrcM,
   output logic [DATA_WIDTH-1:0]             PCPlus4M,
   output logic [DATA_WIDTH-1:0]             ReadDataM,
   output logic                              MemBusyM,
   output logic                              MisalignM,
   output logic                              mem_req_valid,
   input  logic                              mem_req_ready,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic                              mem_we,
   output logic [3:0]                        mem_wstrb,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   input  logic                              mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic [1:0]                        lsu_state_dbg
);

   logic [DATA_WIDTH-1:0]             r_alu_result;
   logic [DATA_WIDTH-1:0]             r_write_data;
   logic [REG_FILE_ADDRESS_WIDTH-1:0] r_rd;
   logic                              r_reg_write;
   logic                              r_mem_read;
   logic                              r_mem_write;
   logic [2:0]                        r_funct3;
   logic [1:0]                        r_result_src;
   logic [DATA_WIDTH-1:0]             r_pc_plus4;
   logic [DATA_WIDTH-1:0]             r_read_data;
   lsu_state_t                        r_state;
   lsu_state_t                        w_next_state;
   logic                              w_capture;
   logic                              w_mem_op;
   logic                              w_misalign;
   logic                              w_op;
   logic [3:0]                        w_wstrb;
   logic [DATA_WIDTH-1:0]             w_load_data;

   // EX/MEM register: advance whenever no access is stalling the pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_result <= '0;
         r_write_data <= '0;
         r_rd         <= '0;
         r_reg_write  <= 1'b0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_funct3     <= '0;
         r_result_src <= '0;
         r_pc_plus4   <= '0;
      end else if (!MemBusyM) begin
         r_alu_result <= ALUResultE;
         r_write_data <= WriteDataE;
         r_rd         <= RdE;
         r_reg_write  <= RegWriteE;
         r_mem_read   <= MemReadE;
         r_mem_write  <= MemWriteE;
         r_funct3     <= Funct3E;
         r_result_src <= ResultSrcE;
         r_pc_plus4   <= PCPlus4E;
      end
   end

   // Misaligned half/word accesses are suppressed entirely
   assign w_mem_op   = r_mem_read | r_mem_write;
   assign w_misalign = w_mem_op &
                       ((is_half(r_funct3) & r_alu_result[0]) |
                        (!is_byte(r_funct3) && !is_half(r_funct3) &&
                         (r_alu_result[1:0] != 2'b00)));
   assign w_op       = w_mem_op & ~w_misalign;

   // LSU state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   // LSU next state and request valid
   always_comb begin
      w_next_state  = r_state;
      mem_req_valid = 1'b0;
      w_capture     = 1'b0;
      case (r_state)
         IDLE: begin
            mem_req_valid = w_op;
            if (w_op && mem_req_ready) w_next_state = r_mem_write ? DONE : WAIT;
         end
         WAIT: begin
            if (mem_rsp_valid) begin
               w_capture    = 1'b1;
               w_next_state = DONE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Load data register: only updated when a response completes a load
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            r_read_data <= '0;
      else if (w_capture) r_read_data <= w_load_data;
   end

   load_store_align u_align (
      .i_funct3     (r_funct3),
      .i_addr_lo    (r_alu_result[1:0]),
      .i_store_data (r_write_data),
      .i_load_word  (mem_rdata),
      .o_wstrb      (w_wstrb),
      .o_wdata      (mem_wdata),
      .o_load_data  (w_load_data)
   );

   assign MemBusyM      = w_op & (r_state != DONE);
   assign MisalignM     = w_misalign;
   assign ALUResultM    = r_alu_result;
   assign RdM           = r_rd;
   assign RegWriteM     = r_reg_write & ~w_misalign;
   assign ResultSrcM    = r_result_src;
   assign PCPlus4M      = r_pc_plus4;
   assign ReadDataM     = r_read_data;
   assign mem_addr      = {r_alu_result[ADDR_WIDTH-1:2], 2'b00};
   assign mem_we        = r_mem_write & ~w_misalign;
   assign mem_wstrb     = mem_we ? w_wstrb : 4'b0000;
   assign lsu_state_dbg = r_state;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, store lane steering,
// load extension, request stalling under backpressure, misalign
// suppression and reset during an outstanding load.
module tb_memory_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
   logic [4:0]  RdE;
   logic        RegWriteE, MemReadE, MemWriteE;
   logic [2:0]  Funct3E;
   logic [1:0]  ResultSrcE;
   logic [31:0] ALUResultM, PCPlus4M, ReadDataM;
   logic [4:0]  RdM;
   logic        RegWriteM, MemBusyM, MisalignM;
   logic [1:0]  ResultSrcM;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [1:0]  lsu_state_dbg;

   int checks   = 0;
   int failures = 0;

   memory_stage dut (
      .clk(clk), .rst(rst),
      .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE),
      .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
      .Funct3E(Funct3E), .ResultSrcE(ResultSrcE), .PCPlus4E(PCPlus4E),
      .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM),
      .ResultSrcM(ResultSrcM), .PCPlus4M(PCPlus4M), .ReadDataM(ReadDataM),
      .MemBusyM(MemBusyM), .MisalignM(MisalignM),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata), .lsu_state_dbg(lsu_state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   task automatic set_ex(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] wd, input logic mr, input logic mw,
                         input logic [2:0] f3, input logic [1:0] rs, input logic [31:0] pc4);
      RegWriteE = rw; RdE = rd; ALUResultE = alu; WriteDataE = wd;
      MemReadE = mr; MemWriteE = mw; Funct3E = f3; ResultSrcE = rs; PCPlus4E = pc4;
   endtask

   task automatic set_nop();
      set_ex(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Store with ready=1: check request fields in the accept cycle and count stalls
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata);
      int stalls;
      mem_req_ready = 1'b1;
      set_ex(1'b0, 5'd0, addr, data, 1'b0, 1'b1, f3, 2'b00, 32'h0);
      tick();
      set_nop();
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (MemBusyM) stalls++;
         if (c == 0) begin
            check_eq({tag, "_valid"}, {31'b0, mem_req_valid}, 32'd1);
            check_eq({tag, "_we"},    {31'b0, mem_we}, 32'd1);
            check_eq({tag, "_addr"},  mem_addr, {addr[31:2], 2'b00});
            check_eq({tag, "_strb"},  {28'b0, mem_wstrb}, {28'b0, exp_strb});
            check_eq({tag, "_wdata"}, mem_wdata, exp_wdata);
         end
         tick();
      end
      check_eq({tag, "_stalls"}, stalls, 32'd1);
   endtask

   // Load with ready=1 and a response one cycle after acceptance
   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] word, input logic [31:0] exp);
      int   stalls;
      logic acc;
      mem_req_ready = 1'b1;
      set_ex(1'b1, 5'd7, addr, 32'h0, 1'b1, 1'b0, f3, 2'b01, 32'h0);
      tick();
      set_nop();
      stalls = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (MemBusyM) stalls++;
         acc = mem_req_valid & mem_req_ready & ~mem_we;
         if (c == 0) check_eq({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
         if (c == 2) check_eq({tag, "_rd"}, {27'b0, RdM}, 32'd7);
         tick();
         mem_rsp_valid = acc;
         mem_rdata     = acc ? word : 32'h0;
      end
      mem_rsp_valid = 1'b0;
      check_eq({tag, "_data"}, ReadDataM, exp);
      check_eq({tag, "_stalls"}, stalls, 32'd2);
   endtask

   initial begin
      rst = 1'b1; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
      set_nop();
      repeat (2) @(negedge clk);
      check_eq("rst_alu",   ALUResultM, 32'h0);
      check_eq("rst_busy",  {31'b0, MemBusyM}, 32'h0);
      check_eq("rst_valid", {31'b0, mem_req_valid}, 32'h0);
      check_eq("rst_strb",  {28'b0, mem_wstrb}, 32'h0);
      check_eq("rst_rdata", ReadDataM, 32'h0);
      check_eq("rst_state", {30'b0, lsu_state_dbg}, 32'd0);
      rst = 1'b0;

      // ALU op passes through in one cycle with no stall
      tick();
      set_ex(1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h44);
      tick();
      set_nop();
      @(negedge clk);
      check_eq("alu_result", ALUResultM, 32'h1234);
      check_eq("alu_rd",     {27'b0, RdM}, 32'd5);
      check_eq("alu_rw",     {31'b0, RegWriteM}, 32'd1);
      check_eq("alu_pc4",    PCPlus4M, 32'h44);
      check_eq("alu_busy",   {31'b0, MemBusyM}, 32'd0);
      check_eq("alu_valid",  {31'b0, mem_req_valid}, 32'd0);

      // Stores
      do_store("sb", 3'b000, 32'h103, 32'h000000AB, 4'b1000, 32'hABABABAB);
      do_store("sb1", 3'b000, 32'h101, 32'h00000055, 4'b0010, 32'h55555555);
      do_store("sh", 3'b001, 32'h102, 32'h1234BEEF, 4'b1100, 32'hBEEFBEEF);
      do_store("sw", 3'b010, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);

      // Loads
      do_load("lh",  3'b001, 32'h102, 32'h80011234, 32'hFFFF8001);
      do_load("lhu", 3'b101, 32'h102, 32'h80011234, 32'h00008001);
      do_load("lb",  3'b000, 32'h101, 32'h0000F300, 32'hFFFFFFF3);
      do_load("lbu", 3'b100, 32'h101, 32'h0000F300, 32'h000000F3);
      do_load("lw",  3'b010, 32'h108, 32'h7654ABCD, 32'h7654ABCD);
      check_eq("rdata_hold", ReadDataM, 32'h7654ABCD);

      // LW held off by ready=0 for 3 cycles
      mem_req_ready = 1'b0;
      set_ex(1'b1, 5'd9, 32'h200, 32'h0, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0);
      tick();
      set_ex(1'b1, 5'd3, 32'hDEAD, 32'h0, 1'b0, 1'b0, 3'b000, 2'b00, 32'h0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_eq("bp_valid", {31'b0, mem_req_valid}, 32'd1);
         check_eq("bp_addr",  mem_addr, 32'h200);
         check_eq("bp_hold",  ALUResultM, 32'h200);
         check_eq("bp_busy",  {31'b0, MemBusyM}, 32'd1);
         tick();
      end
      mem_req_ready = 1'b1;
      tick();
      mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      check_eq("bp_wait_busy", {31'b0, MemBusyM}, 32'd1);
      check_eq("bp_wait_valid", {31'b0, mem_req_valid}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_data", ReadDataM, 32'hCAFEF00D);
      check_eq("bp_done_busy", {31'b0, MemBusyM}, 32'd0);
      check_eq("bp_rd", {27'b0, RdM}, 32'd9);
      tick();
      set_nop();
      @(negedge clk);
      check_eq("bp_next_alu", ALUResultM, 32'hDEAD);
      check_eq("bp_next_rd",  {27'b0, RdM}, 32'd3);

      // Misaligned word store is suppressed
      set_ex(1'b1, 5'd4, 32'h102, 32'h11111111, 1'b0, 1'b1, 3'b010, 2'b00, 32'h0);
      tick();
      set_nop();
      @(negedge clk);
      check_eq("mis_flag",  {31'b0, MisalignM}, 32'd1);
      check_eq("mis_valid", {31'b0, mem_req_valid}, 32'd0);
      check_eq("mis_rw",    {31'b0, RegWriteM}, 32'd0);
      check_eq("mis_busy",  {31'b0, MemBusyM}, 32'd0);
      check_eq("mis_strb",  {28'b0, mem_wstrb}, 32'd0);
      tick();

      // Reset while a load waits for its response
      mem_req_ready = 1'b1;
      set_ex(1'b1, 5'd8, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010, 2'b01, 32'h0);
      tick();
      set_nop();
      tick();
      @(negedge clk);
      check_eq("rw_state_wait", {30'b0, lsu_state_dbg}, 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rw_state", {30'b0, lsu_state_dbg}, 32'd0);
      check_eq("rw_alu",   ALUResultM, 32'h0);
      check_eq("rw_busy",  {31'b0, MemBusyM}, 32'd0);
      check_eq("rw_rdata", ReadDataM, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      mem_rsp_valid = 1'b1; mem_rdata = 32'h12345678;
      @(negedge clk);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      check_eq("rw_drop_rdata", ReadDataM, 32'h0);
      check_eq("rw_drop_state", {30'b0, lsu_state_dbg}, 32'd0);
      check_eq("rw_drop_valid", {31'b0, mem_req_valid}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Overall time bound so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
